// File: rtl/tracker_query_scheduler.sv
// Round-robin scheduler that serialises lookback queries and previous-end
// overrides onto a single shared signal tracker and returns tagged results.
module tracker_query_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int BUFFER_WIDTH  = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_lookback,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [31:0]                resp_start,
  output logic [31:0]                resp_end,
  output logic [1:0]                 resp_status,
  input  logic                       end_ovr_valid,
  input  logic [31:0]                end_ovr_value,
  output logic                       end_ovr_ready,
  output logic [31:0]                trk_value_o,
  output logic                       trk_recalc_o,
  input  logic [63:0]                trk_time_i,
  output logic                       trk_update_end_o,
  output logic [31:0]                trk_previous_end_o
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_ENDUPD, S_ISSUE, S_PULSE, S_WAIT, S_CAPTURE, S_RESP
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           gnt_found;
  logic [31:0]    gnt_lb;
  logic           lb_legal;
  logic [31:0]    wait_cnt;
  logic [31:0]    cap_start;
  logic [31:0]    cap_end;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt_lb    = req_lookback[32*gnt_idx +: 32];
  assign lb_legal  = (gnt_lb != 32'd0) && (gnt_lb <= 32'(BUFFER_WIDTH));
  assign cap_start = trk_time_i[31:0];
  assign cap_end   = trk_time_i[63:32];

  always_comb begin
    state_n       = state;
    req_ready     = '0;
    end_ovr_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (end_ovr_valid) begin
          end_ovr_ready = 1'b1;
          state_n       = S_ENDUPD;
        end else if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          state_n            = lb_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ENDUPD:  state_n = S_IDLE;
      S_ISSUE:   state_n = S_PULSE;
      S_PULSE:   state_n = S_WAIT;
      S_WAIT:    if (wait_cnt == 32'(SETTLE_CYCLES - 1)) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_RESP;
      S_RESP:    if (resp_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  assign trk_recalc_o     = (state == S_PULSE);
  assign trk_update_end_o = (state == S_ENDUPD);
  assign resp_valid       = (state == S_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      ptr                <= '0;
      wait_cnt           <= '0;
      trk_value_o        <= '0;
      trk_previous_end_o <= '0;
      resp_id            <= '0;
      resp_start         <= '1;
      resp_end           <= '1;
      resp_status        <= 2'b00;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (end_ovr_valid) begin
            trk_previous_end_o <= end_ovr_value;
          end else if (gnt_found) begin
            ptr     <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            resp_id <= gnt_idx;
            // Rejected lookbacks leave the tracker value untouched.
            if (lb_legal) begin
              trk_value_o <= gnt_lb;
            end else begin
              resp_start  <= '1;
              resp_end    <= '1;
              resp_status <= 2'b10;
            end
          end
        end
        S_PULSE: wait_cnt <= '0;
        S_WAIT:  wait_cnt <= wait_cnt + 32'd1;
        S_CAPTURE: begin
          resp_start <= cap_start;
          resp_end   <= cap_end;
          if (cap_start == '1)    resp_status <= 2'b00;
          else if (cap_end == '1) resp_status <= 2'b01;
          else                    resp_status <= 2'b11;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/tracker_query_scheduler.md
Name: tracker_query_scheduler

Overview:
- Arbitrates timing-interval queries from NUM_REQ requesters (one per pipeline-stage tracer) onto one shared signal-tracker instance.
- Sequences the tracker's lookback value and recalculate pulse, then waits a settle window and captures the start/end pair.
- Returns each result on a single tagged response channel.
- Also serialises externally supplied previous-end overrides into the tracker so that queries never interleave with end updates.

Parameters:
NUM_REQ, 4, number of requesters; at least 2
BUFFER_WIDTH, 8, depth of the tracker history buffer; power of 2; legal lookback range is 1..BUFFER_WIDTH
SETTLE_CYCLES, 1, cycles between the recalc pulse and result capture; at least 1

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester query request
req_lookback  in  NUM_REQ*32  per-requester lookback in cycles, unsigned; slice i = bits [32i+31:32i]
req_ready  out  NUM_REQ  one-hot grant, 1-cycle pulse
resp_valid  out  1  response available
resp_ready  in  1  response consumed
resp_id  out  $clog2(NUM_REQ)  index of the requester being answered
resp_start  out  32 signed  interval start cycle, or -1
resp_end  out  32 signed  interval end cycle, or -1
resp_status  out  2  00 no start; 01 open (start only); 11 complete; 10 rejected
end_ovr_valid  in  1  previous-end override request
end_ovr_value  in  32  override value
end_ovr_ready  out  1  override accepted, 1-cycle pulse
trk_value_o  out  32  lookback driven to the tracker
trk_recalc_o  out  1  recalculate pulse to the tracker
trk_time_i  in  2x32 signed  tracker result; [0] is start, [1] is end
trk_update_end_o  out  1  end-update strobe to the tracker
trk_previous_end_o  out  32  end value driven to the tracker

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - All ready/valid/strobe outputs are 0; trk_value_o=0, trk_previous_end_o=0.
  - resp_start=resp_end=-1, resp_status=00, resp_id=0.
  - A reset mid-operation discards the in-flight query; no response is issued for it.
- FSM states: IDLE, ENDUPD, ISSUE, PULSE, WAIT, CAPTURE, RESP.
- IDLE priority:
  - If end_ovr_valid: assert end_ovr_ready, latch end_ovr_value, go to ENDUPD. Overrides take priority over queries in the same cycle.
  - Else if any req_valid: grant the lowest index at or after the pointer (wrapping). Assert req_ready[g] for 1 cycle, latch lookback and id, set pointer to (g+1) mod NUM_REQ.
  - A granted lookback of 0 or greater than BUFFER_WIDTH goes directly to RESP with status 10 and start=end=-1. The tracker is not touched.
  - A legal lookback goes to ISSUE.
- ENDUPD (1 cycle):
  - trk_update_end_o=1 and trk_previous_end_o=latched value; then IDLE.
  - trk_previous_end_o holds that value after ENDUPD ends.
- ISSUE (1 cycle): trk_value_o=lookback, recalc=0. trk_value_o holds until the next grant.
- PULSE (1 cycle): trk_recalc_o=1, giving exactly one rising edge per query.
- WAIT: SETTLE_CYCLES cycles with recalc=0.
- CAPTURE (1 cycle): register trk_time_i, then derive status:
  - start=-1 gives 00.
  - start!=-1 and end=-1 gives 01.
  - both !=-1 gives 11.
- RESP:
  - resp_valid=1 with id, start, end and status held stable until resp_ready=1 is sampled; then IDLE.
  - No new grant is issued before that handshake completes.
- Latency:
  - Legal query: grant at cycle T; PULSE at T+2; resp_valid first high at T+4+SETTLE_CYCLES.
  - Rejected query: resp_valid at T+1.
- req_ready and end_ovr_ready are never asserted outside IDLE, and at most one of them is high in any cycle.
- Requests are level-held by requesters until granted. Deasserting req_valid before grant is legal and causes no grant.
- Fairness: with all NUM_REQ requests held permanently, each requester is granted once in every NUM_REQ consecutive grants.

Test Plan:
- Single query, NUM_REQ=4, SETTLE=1: req 2 with lookback 3, tracker returns {10,12}.
  - Required: req_ready[2] at T; trk_recalc_o high only at T+2; resp_valid at T+5 with id=2, start=10, end=12, status=11.
- Round-robin: req 0, 1 and 3 held high, resp_ready tied to 1.
  - Required: grant order 0, 1, 3, 0, 1, 3.
  - Then req 3 alone after a grant to 3: grant goes to 3 again.
- Rejection: lookback 0, then lookback 9 (BUFFER_WIDTH=8).
  - Required: each gives resp_valid 1 cycle after grant with status 10, start=end=-1, and no trk_recalc_o pulse.
- Override priority: end_ovr_valid with value 40 and req_valid[1] in the same IDLE cycle.
  - Required: end_ovr_ready first, trk_update_end_o for 1 cycle with trk_previous_end_o=40; req_ready[1] two cycles later.
- Backpressure: tracker returns {7,-1} and resp_ready is held 0 for 5 cycles.
  - Required: status 01, start=7, end=-1, all held stable; no req_ready during the stall.
  - After resp_ready=1, a new grant occurs the next cycle.
- Reset mid-query: rst_n=0 during WAIT.
  - Required: the next cycle has resp_valid=0, trk_recalc_o=0, pointer=0, and no response for the dropped query.
  - After release, req 0 is granted first.
